pb_vernam_mailbox: RTL

Parametrised keystream mailbox between two kcpsm3 cores: a producer core (keystream generator) pushes key bytes into a FIFO, and a consumer core (cipher core) pops them via INPUT or has them XORed in hardware against plaintext via OUTPUT. It replaces direct port_id-to-in_port wiring and the fixed four-way input mux with a buffered, flow-controlled, port-decoded link that carries status flags. It sits between the two cores' port buses and drives both in_port buses plus a registered cipher output.

---
 rtl/pb_vernam_mailbox.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pb_vernam_mailbox.sv
// Keystream mailbox between two kcpsm3 cores: the producer pushes key bytes into a FIFO,
// and the consumer pops them raw or XORs them against plaintext into a cipher register.
module pb_vernam_mailbox #(
  parameter int         DEPTH       = 16,
  parameter logic [7:0] KEY_PORT    = 8'h01,
  parameter logic [7:0] STATUS_PORT = 8'h02,
  parameter logic [7:0] COUNT_PORT  = 8'h03,
  parameter logic [7:0] POP_PORT    = 8'h40,
  parameter logic [7:0] XOR_PORT    = 8'h41,
  parameter logic [7:0] CIPHER_PORT = 8'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] p_port_id,
  input  logic [7:0] p_out_port,
  input  logic       p_write_strobe,
  input  logic       p_read_strobe,
  output logic [7:0] p_in_port,
  input  logic [7:0] c_port_id,
  input  logic [7:0] c_out_port,
  input  logic       c_write_strobe,
  input  logic       c_read_strobe,
  output logic [7:0] c_in_port,
  output logic [7:0] cipher_out,
  output logic       cipher_valid
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic [7:0]    cipher_q, cipher_d;
  logic          cv_q, cv_d;
  logic [7:0]    p_in_q, p_in_d, c_in_q, c_in_d;

  logic       empty, full;
  logic [7:0] head, status, count_byte;
  logic [8:0] count_ext;
  logic       push_req, pop_rd, pop_xor, pop_req, push_ok, pop_ok;
  logic       ovf_set, unf_set, ovf_clr, unf_clr;
  logic       unused_ok;

  // The producer's read strobe only selects in_port timing inside the core; nothing here acts on it.
  assign unused_ok = p_read_strobe;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign status     = {4'b0000, unf_q, ovf_q, full, empty};
  assign count_ext  = 9'(count_q);
  assign count_byte = count_ext[8] ? 8'hFF : count_ext[7:0];

  assign push_req = p_write_strobe && (p_port_id == KEY_PORT);
  assign pop_rd   = c_read_strobe  && (c_port_id == POP_PORT);
  assign pop_xor  = c_write_strobe && (c_port_id == XOR_PORT);
  assign pop_req  = pop_rd || pop_xor;
  // Full/empty decisions use pre-edge occupancy, so a same-cycle partner never rescues a request.
  assign push_ok  = push_req && !full;
  assign pop_ok   = pop_req && !empty;
  assign ovf_set  = push_req && full;
  assign unf_set  = pop_req && empty;
  assign ovf_clr  = (p_write_strobe && (p_port_id == STATUS_PORT) && p_out_port[2]) ||
                    (c_write_strobe && (c_port_id == STATUS_PORT) && c_out_port[2]);
  assign unf_clr  = (p_write_strobe && (p_port_id == STATUS_PORT) && p_out_port[3]) ||
                    (c_write_strobe && (c_port_id == STATUS_PORT) && c_out_port[3]);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d    = (ovf_q && !ovf_clr) || ovf_set;
    unf_d    = (unf_q && !unf_clr) || unf_set;
    cipher_d = cipher_q;
    cv_d     = 1'b0;
    if (pop_xor && !empty) begin
      cipher_d = c_out_port ^ head;
      cv_d     = 1'b1;
    end
  end

  always_comb begin
    p_in_d = 8'h00;
    if (p_port_id == STATUS_PORT)     p_in_d = status;
    else if (p_port_id == COUNT_PORT) p_in_d = count_byte;
    c_in_d = 8'h00;
    if (c_port_id == STATUS_PORT)      c_in_d = status;
    else if (c_port_id == COUNT_PORT)  c_in_d = count_byte;
    else if (c_port_id == POP_PORT)    c_in_d = empty ? 8'h00 : head;
    else if (c_port_id == CIPHER_PORT) c_in_d = cipher_q;
  end

  // Storage is not reset; pointer and count reset make stale bytes unreachable.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= p_out_port;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      cipher_q <= 8'h00;
      cv_q     <= 1'b0;
      p_in_q   <= 8'h00;
      c_in_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      cipher_q <= cipher_d;
      cv_q     <= cv_d;
      p_in_q   <= p_in_d;
      c_in_q   <= c_in_d;
    end
  end

  assign p_in_port    = p_in_q;
  assign c_in_port    = c_in_q;
  assign cipher_out   = cipher_q;
  assign cipher_valid = cv_q;
endmodule
